// File: rtl/gnrl_sync_filt.sv
// rtl/gnrl_sync_filt.sv - multi-bit CDC synchronizer with per-bit glitch filter
// Optional edge-pulse outputs are built when GNRL_SYNC_EDGE_EN is defined.
module gnrl_sync_filt #(
  parameter int              DW            = 8,
  parameter logic [DW-1:0]   DEF_VAL       = '0,
  parameter int              SYNC_PIPE_NUM = 2,
  parameter int              FILT_CYC      = 4,
  parameter int              END_OF_LIST   = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic [DW-1:0] o_rise,
  output logic [DW-1:0] o_fall,
  output logic [DW-1:0] o_pend
);

  localparam int            CW      = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // END_OF_LIST only terminates the parameter list; it carries no function.
  if (END_OF_LIST != 1) begin : g_eol_unused
  end

  logic [DW-1:0] sync_q [SYNC_PIPE_NUM];
  logic [DW-1:0] s;
  logic [DW-1:0] f_q;
  logic [DW-1:0] f_d;
  logic [CW-1:0] cnt_q [DW];
  logic [CW-1:0] cnt_d [DW];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SYNC_PIPE_NUM; k++) sync_q[k] <= DEF_VAL;
    end else begin
      sync_q[0] <= i_data;
      for (int k = 1; k < SYNC_PIPE_NUM; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_PIPE_NUM-1];

  // A bit that returns to the accepted value restarts its qualification.
  always_comb begin
    f_d = f_q;
    for (int i = 0; i < DW; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == f_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        f_d[i]   = s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f_q <= DEF_VAL;
      for (int i = 0; i < DW; i++) cnt_q[i] <= '0;
    end else begin
      f_q <= f_d;
      for (int i = 0; i < DW; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    o_pend = '0;
    for (int i = 0; i < DW; i++) o_pend[i] = (cnt_q[i] != '0);
  end

  assign o_data = f_q;

`ifdef GNRL_SYNC_EDGE_EN
  logic [DW-1:0] rise_q;
  logic [DW-1:0] fall_q;

  // f only changes on an accepted update, so its transition is the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= f_d & ~f_q;
      fall_q <= ~f_d & f_q;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;
`else
  assign o_rise = '0;
  assign o_fall = '0;
`endif

endmodule

// File: tb/tb_gnrl_sync_filt.sv
// tb/tb_gnrl_sync_filt.sv - scoreboard bench for gnrl_sync_filt
// Edge expectations follow GNRL_SYNC_EDGE_EN as seen by this compilation.
module tb_gnrl_sync_filt;

  localparam int            DW   = 4;
  localparam logic [DW-1:0] DEF  = 4'b0101;
  localparam int            SYNC = 2;
  localparam int            FILT = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [DW-1:0] p;
    logic [DW-1:0] r;
    logic [DW-1:0] f;
  } exp_t;

  logic          clk;
  logic          i_rst_n;
  logic [DW-1:0] i_data;
  logic [DW-1:0] o_data;
  logic [DW-1:0] o_rise;
  logic [DW-1:0] o_fall;
  logic [DW-1:0] o_pend;

  exp_t          exp_q[$];
  logic [DW-1:0] hist[$];
  int            run[DW];
  logic [DW-1:0] m_f;
  logic [DW-1:0] m_pend;
  logic [DW-1:0] m_rise;
  logic [DW-1:0] m_fall;
  int            n_cmp;
  int            n_err;

  gnrl_sync_filt #(
    .DW(DW), .DEF_VAL(DEF), .SYNC_PIPE_NUM(SYNC), .FILT_CYC(FILT), .END_OF_LIST(1)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_data(i_data),
    .o_data(o_data), .o_rise(o_rise), .o_fall(o_fall), .o_pend(o_pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    hist.delete();
    m_f    = DEF;
    m_pend = '0;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < DW; i++) run[i] = 0;
  endtask

  // s is simply the input value seen SYNC edges earlier; a bit is accepted
  // after it has disagreed with the output for FILT edges in a row.
  task automatic model_edge(input logic [DW-1:0] x);
    logic [DW-1:0] s;
    s = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : DEF;
    hist.push_back(x);
    if (hist.size() > SYNC) void'(hist.pop_front());
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < DW; i++) begin
      if (s[i] == m_f[i]) begin
        run[i] = 0;
      end else begin
        run[i] = run[i] + 1;
        if (run[i] == FILT) begin
          m_f[i] = s[i];
          run[i] = 0;
          if (s[i]) m_rise[i] = 1'b1;
          else      m_fall[i] = 1'b1;
        end
      end
      m_pend[i] = (run[i] != 0);
    end
  endtask

  task automatic tick(input logic rst_next, input logic [DW-1:0] din);
    exp_t e;
    @(posedge clk);
    #1;
    if (i_rst_n) model_edge(i_data);
    i_rst_n = rst_next;
    i_data  = din;
    if (!rst_next) model_reset();
    e.d = m_f;
    e.p = m_pend;
`ifdef GNRL_SYNC_EDGE_EN
    e.r = m_rise;
    e.f = m_fall;
`else
    e.r = '0;
    e.f = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("o_data", o_data, e.d);
        check("o_pend", o_pend, e.p);
        check("o_rise", o_rise, e.r);
        check("o_fall", o_fall, e.f);
      end
    end
  end

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] bounce [6];
    int hold;
    n_cmp   = 0;
    n_err   = 0;
    i_rst_n = 1'b0;
    i_data  = 4'b1111;
    model_reset();

    // Reset with a non-default input, then release and let it qualify.
    for (int c = 0; c < 3; c++) tick(1'b0, 4'b1111);
    tick(1'b1, 4'b1111);
    for (int c = 0; c < 8; c++) tick(1'b1, 4'b1111);

    // Clean change, then a 2-cycle glitch on bit 1.
    for (int c = 0; c < 8; c++) tick(1'b1, 4'b0101);
    for (int c = 0; c < 8; c++) tick(1'b1, 4'b0100);
    tick(1'b1, 4'b0110);
    tick(1'b1, 4'b0110);
    for (int c = 0; c < 8; c++) tick(1'b1, 4'b0100);

    // Bounce on bit 3: 1,1,0,1,1,1.
    bounce[0] = 4'b1100; bounce[1] = 4'b1100; bounce[2] = 4'b0100;
    bounce[3] = 4'b1100; bounce[4] = 4'b1100; bounce[5] = 4'b1100;
    for (int c = 0; c < 6; c++) tick(1'b1, bounce[c]);
    for (int c = 0; c < 8; c++) tick(1'b1, 4'b1100);

    // Reset in the middle of qualifying a bit-1 change.
    for (int c = 0; c < 4; c++) tick(1'b1, 4'b1110);
    tick(1'b0, 4'b1110);
    tick(1'b0, 4'b1110);
    tick(1'b1, 4'b1110);
    for (int c = 0; c < 8; c++) tick(1'b1, 4'b1110);

    // Randomized holds, with occasional asynchronous resets.
    for (int n = 0; n < 150; n++) begin
      v    = DW'($urandom);
      hold = $urandom_range(1, 6);
      if ($urandom_range(0, 24) == 0) begin
        tick(1'b0, v);
        tick(1'b0, v);
        tick(1'b1, v);
      end
      for (int c = 0; c < hold; c++) tick(1'b1, v);
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
